// File: rtl/seq_divider.sv
// Iterative restoring divider returning RISC-V DIV/DIVU/REM/REMU results.
// Signed operands are divided as magnitudes and the signs are restored in
// a single fixup cycle; divide-by-zero and signed overflow bypass the loop.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for Start
//   DIVIDE | one shift-subtract iteration per cycle, WIDTH cycles
//   FIXUP  | apply sign correction and load Quotient/Remainder
//   DONE   | Done high for one cycle; Start here chains a new request
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed_Op,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIXUP, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] wq;
  logic [WIDTH-1:0] dvsr;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             div_zero;
  logic             sign_ovf;
  logic             special;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shift_in;
  logic [WIDTH:0]   trial;

  // Request qualification and the zero-iteration special cases.
  assign accept   = Start && ((state == S_IDLE) || (state == S_DONE));
  assign div_zero = (Divisor == '0);
  assign sign_ovf = Signed_Op && (Dividend == MOST_NEG) && (Divisor == '1);
  assign special  = div_zero || sign_ovf;

  // The most-negative value negates to itself, which is its correct
  // magnitude when read as unsigned.
  assign dvd_mag = (Signed_Op && Dividend[WIDTH-1]) ? -Dividend : Dividend;
  assign dvs_mag = (Signed_Op && Divisor[WIDTH-1])  ? -Divisor  : Divisor;

  // acc < dvsr holds throughout, so bit WIDTH of the trial is a true sign bit.
  assign shift_in = {acc, wq[WIDTH-1]};
  assign trial    = shift_in - {1'b0, dvsr};

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? (special ? S_DONE : S_DIVIDE) : S_IDLE;
      S_DIVIDE:       if (cnt == LAST_ITER) state_nxt = S_FIXUP;
      S_FIXUP:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      S_DIVIDE, S_FIXUP: Busy = 1'b1;
      S_DONE:            Done = 1'b1;
      default:           ;
    endcase
  end

  // Operand capture, shift-subtract iterations and result load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      acc       <= '0;
      wq        <= '0;
      dvsr      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (div_zero) begin
              Quotient  <= '1;
              Remainder <= Dividend;
            end else if (sign_ovf) begin
              Quotient  <= Dividend;
              Remainder <= '0;
            end else begin
              cnt   <= '0;
              acc   <= '0;
              wq    <= dvd_mag;
              dvsr  <= dvs_mag;
              q_neg <= Signed_Op && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
              r_neg <= Signed_Op && Dividend[WIDTH-1];
            end
          end
        end
        S_DIVIDE: begin
          acc <= trial[WIDTH] ? shift_in[WIDTH-1:0] : trial[WIDTH-1:0];
          wq  <= {wq[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + CW'(1);
        end
        S_FIXUP: begin
          Quotient  <= q_neg ? -wq  : wq;
          Remainder <= r_neg ? -acc : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a transaction-level reference model
// (arithmetic result plus fixed latency) is compared every cycle, and
// directed vectors carry hand-computed literal results and latencies.
module tb_seq_divider;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         Signed_Op = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Signed_Op(Signed_Op),
    .Dividend(Dividend), .Divisor(Divisor), .Busy(Busy), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder)
  );

  always #5 Clk = ~Clk;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // RISC-V division semantics from plain integer arithmetic.
  task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic spc);
    int sa, sb;
    sa = a;
    sb = b;
    spc = 1'b0;
    if (b == 0) begin
      q = '1; r = a; spc = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; spc = 1'b1;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Transaction model: cycles remaining until the result appears.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;

  always @(posedge Clk) begin
    logic [W-1:0] q, r;
    logic spc;
    logic nd;
    nd = 1'b0;
    if (Reset) begin
      m_left = 0; m_q = '0; m_r = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_q = m_pq; m_r = m_pr; nd = 1'b1;
      end
    end else if (Start) begin
      ref_div(Signed_Op, Dividend, Divisor, q, r, spc);
      if (spc) begin
        m_q = q; m_r = r; nd = 1'b1;
      end else begin
        m_pq = q; m_pr = r; m_left = W + 1;
      end
    end
    m_done = nd;
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    chk("busy", {31'b0, Busy}, {31'b0, (m_left > 0)});
    chk("done", {31'b0, Done}, {31'b0, m_done});
    chk("quotient", Quotient, m_q);
    chk("remainder", Remainder, m_r);
  end

  // Issue one request at the current falling edge and wait for Done.
  task automatic do_div(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
    int n, nbusy;
    Signed_Op = s; Dividend = a; Divisor = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 1;
    nbusy = 0;
    while (!Done && n < 100) begin
      if (Busy) nbusy++;
      @(negedge Clk);
      n++;
    end
    chk({tag, "_done_seen"}, {31'b0, Done}, 32'd1);
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_busy_cycles"}, nbusy, elat - 1);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  initial begin
    int n;
    idle(2);
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_q", Quotient, 32'd0);
    chk("reset_r", Remainder, 32'd0);
    Reset = 1'b0;
    idle(1);

    // Basic unsigned division and hold afterwards.
    do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, NORMAL_LAT);
    idle(10);
    chk("hold_q", Quotient, 32'd14);
    chk("hold_r", Remainder, 32'd2);

    // Signed sign combinations and unsigned full-range.
    do_div("sn100_7", 1'b1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, NORMAL_LAT);
    idle(1);
    do_div("s100_n7", 1'b1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'h0000_0002, NORMAL_LAT);
    idle(1);
    do_div("s_n7_n2", 1'b1, -32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, NORMAL_LAT);
    idle(1);
    do_div("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, NORMAL_LAT);
    idle(1);

    // Divide by zero in both modes.
    do_div("u_div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    idle(1);
    do_div("s_div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    idle(1);

    // Most-negative dividend by -1.
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1);
    idle(1);
    do_div("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, NORMAL_LAT);
    idle(1);

    // Start while busy is ignored; Start in the Done cycle chains.
    Signed_Op = 1'b0; Dividend = 32'd100; Divisor = 32'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    idle(9);
    Signed_Op = 1'b1; Dividend = 32'd55; Divisor = 32'd5; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 11;
    while (!Done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("ignore_latency", n, NORMAL_LAT);
    chk("ignore_q", Quotient, 32'd14);
    chk("ignore_r", Remainder, 32'd2);
    do_div("b2b", 1'b1, -32'sd1000, 32'd33, 32'hFFFF_FFE2, 32'hFFFF_FFF6, NORMAL_LAT);
    do_div("b2b_div0", 1'b0, 32'hCAFE_0001, 32'd0, 32'hFFFF_FFFF, 32'hCAFE_0001, 1);
    idle(1);

    // Reset in the middle of a division.
    Signed_Op = 1'b0; Dividend = 32'd12345; Divisor = 32'd11; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    idle(14);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
    chk("mid_rst_q", Quotient, 32'd0);
    chk("mid_rst_r", Remainder, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) n++;
    end
    chk("mid_rst_no_done", n, 0);
    do_div("u81_9", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, NORMAL_LAT);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative shift-subtract (restoring) divider. It is the inverse datapath of the shift-add multiplier and sits beside it in the M-extension execute unit.
- Accepts one divide request per Start pulse.
- Shifts a remainder/quotient register pair left one bit per cycle.
- Returns RISC-V DIV/DIVU/REM/REMU results with a single-cycle Done pulse.

Parameters:
WIDTH, 32, operand/result width in bits (iteration count = WIDTH)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request strobe; sampled only when Busy=0
Signed_Op  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with Start
Dividend  input  WIDTH  numerator; sampled with Start
Divisor  input  WIDTH  denominator; sampled with Start
Busy  output  1  high while a division is in progress (DIVIDE or FIXUP)
Done  output  1  one-cycle pulse; Quotient/Remainder valid from this cycle on
Quotient  output  WIDTH  result quotient, held until next accepted Start
Remainder  output  WIDTH  result remainder, held until next accepted Start

Behaviour:
- Interface: one clock Clk; Reset is synchronous and active-high. Reset wins over every other input in the same cycle.
- Reset values: Busy=0, Done=0, Quotient=0, Remainder=0. FSM=IDLE, iteration counter=0.
- States:
  - IDLE
  - DIVIDE: WIDTH iterations
  - FIXUP: sign correction and result load
  - DONE: Done=1 for exactly one cycle
- Accept (edge E0): in IDLE or DONE, Start=1 captures the operands and Signed_Op.
  - Signed: latch magnitudes |Dividend| and |Divisor|, plus sign flags q_neg = sign(Dividend) XOR sign(Divisor) and r_neg = sign(Dividend).
  - Unsigned: sign flags are 0.
  - Then go to DIVIDE with counter=0, remainder accumulator=0, working quotient = dividend magnitude.
- Start while Busy=1: ignored; the operation in flight is unaffected.
- DIVIDE iteration, one per edge, edges E1..E(WIDTH):
  - Form a (WIDTH+1)-bit trial = {acc, wq[MSB]} - {0, divisor}.
  - If non-negative: acc <= trial[WIDTH-1:0] and shift 1 into wq LSB. Otherwise: acc <= {acc, wq[MSB]}[WIDTH-1:0] and shift 0 into wq LSB.
  - wq shifts left every iteration. After the WIDTH-th iteration go to FIXUP.
- FIXUP (edge E(WIDTH+1)):
  - Quotient <= q_neg ? -wq : wq.
  - Remainder <= r_neg ? -acc : acc.
  - Go to DONE.
- Done timing: high during the cycle after E(WIDTH+1). For WIDTH=32 that is 34 cycles after the Start cycle.
- DONE state:
  - Start=1: accept a new request (as in IDLE) and deassert Done next cycle.
  - Start=0: go to IDLE.
- Busy: 1 in DIVIDE and FIXUP; 0 in IDLE and DONE.
- Special cases, decided at E0 with no iterations (FSM goes straight to DONE; Done high the cycle after E0):
  - Divisor=0 (signed or unsigned): Quotient = all ones, Remainder = Dividend.
  - Signed overflow (Dividend = 0x80000000 for WIDTH=32, Divisor = all ones): Quotient = Dividend, Remainder = 0.
- Magnitude of the most-negative value: that value itself, treated as unsigned. The datapath is WIDTH+1 bits internally, so no overflow occurs.
- Outputs Quotient/Remainder change only at FIXUP or at a special-case E0. They are stable in IDLE and DONE.
- Reset mid-operation: next edge returns to IDLE, outputs zeroed, no Done pulse. The in-flight result is discarded.

Test Plan:
1. Unsigned 100 / 7, Start 1 cycle -> Busy 1 for 33 cycles; Done pulses exactly once 34 cycles after Start; Quotient=14, Remainder=2; values held 10 cycles after Done.
2. Signed -100 / 7 and 100 / -7 -> Quotient 0xFFFFFFF2 / 0xFFFFFFF2, Remainder 0xFFFFFFFE / 0x00000002; unsigned 0xFFFFFFFF / 1 -> Q 0xFFFFFFFF, R 0.
3. Divide by zero, Dividend 0x12345678, both signednesses -> Done the cycle after Start, Busy never high; Q 0xFFFFFFFF, R 0x12345678.
4. Signed 0x80000000 / 0xFFFFFFFF -> Done next cycle, Q 0x80000000, R 0. The same operands unsigned -> 34-cycle latency, Q 0, R 0x80000000.
5. Start pulsed with new operands at cycle 10 while Busy -> ignored; original result 100/7 delivered. Start asserted in the Done cycle -> new division accepted back-to-back with correct result.
6. Reset asserted at cycle 15 of a division -> outputs 0, Busy 0, no Done. A following Start of 81 / 9 -> Q 9, R 0.
